// File: rtl/mem_arb_pkg.sv
// Shared types for the three-way memory burst arbiter.
// Requester indices double as bit positions in the req/gnt/ack/done vectors.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [1:0] owner_t;

    localparam int     NUM_REQ    = 3;
    localparam owner_t REQ_MMU    = 2'd0;
    localparam owner_t REQ_DC     = 2'd1;
    localparam owner_t REQ_IC     = 2'd2;
    // Encoding 3 is outside the requester range, so its one-hot form is all zeros.
    localparam owner_t OWNER_NONE = 2'd3;

    function automatic logic [NUM_REQ-1:0] owner_onehot(input owner_t o);
        return NUM_REQ'(1) << o;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side bus of the burst arbiter.
// master = the arbiter; slave = requesters plus the memory model around it.
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ-1:0]           wr;
    logic [NUM_REQ-1:0][31:0]     addr;
    logic [NUM_REQ-1:0][31:0]     wdata;
    logic [NUM_REQ-1:0]           gnt;
    logic [NUM_REQ-1:0]           ack;
    logic [BEAT_W-1:0]            beat;
    logic [31:0]                  rdata;
    logic [NUM_REQ-1:0]           done;

    logic                         mem_HSEL;
    logic                         mem_we;
    logic                         mem_re;
    logic [31:0]                  mem_a;
    logic [31:0]                  mem_wd;
    logic [31:0]                  mem_rd;
    logic                         mem_Valid;

    modport master (
        input  req, wr, addr, wdata, mem_rd, mem_Valid,
        output gnt, ack, beat, rdata, done,
               mem_HSEL, mem_we, mem_re, mem_a, mem_wd
    );

    modport slave (
        output req, wr, addr, wdata, mem_rd, mem_Valid,
        input  gnt, ack, beat, rdata, done,
               mem_HSEL, mem_we, mem_re, mem_a, mem_wd
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: MMU has fixed priority, caches alternate.
// Only meaningful when any_req is set; winner defaults to the MMU otherwise.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  owner_t             rr_last,
    output owner_t             winner,
    output logic               any_req
);

    always_comb begin
        winner  = REQ_MMU;
        any_req = |req;
        if (req[REQ_MMU]) begin
            winner = REQ_MMU;
        end else if (req[REQ_DC] && req[REQ_IC]) begin
            // On a cache tie the one that did not win last time goes first.
            winner = (rr_last == REQ_DC) ? REQ_IC : REQ_DC;
        end else if (req[REQ_DC]) begin
            winner = REQ_DC;
        end else if (req[REQ_IC]) begin
            winner = REQ_IC;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Locks one of MMU / dcache / icache onto the single-ported memory for a
// fixed-length aligned burst; all memory-side outputs decode registered state.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
)(
    input  logic                clk,
    input  logic                reset,
    mem_bus_arbiter_if.master   bus
);

    localparam int          OFFS_W    = $clog2(BURST_LEN) + 2;
    localparam logic [31:0] BASE_MASK = ~((32'd1 << OFFS_W) - 32'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    state_t             state_q, state_d;
    owner_t             owner_q, rr_last_q, winner;
    logic               any_req;
    logic               wr_q;
    logic [31:0]        base_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [NUM_REQ-1:0] own_oh;
    logic               beat_acc;
    logic               last_beat;

    mem_arb_pick u_pick (
        .req     (bus.req),
        .rr_last (rr_last_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign own_oh    = owner_onehot(owner_q);
    assign beat_acc  = (state_q == BURST) && bus.mem_Valid;
    assign last_beat = (beat_q == LAST_BEAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.gnt      = '0;
        bus.ack      = '0;
        bus.done     = '0;
        bus.rdata    = '0;
        bus.mem_HSEL = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_re   = 1'b0;
        bus.mem_a    = '0;
        bus.mem_wd   = '0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = BURST;
            end
            BURST: begin
                bus.gnt      = own_oh;
                bus.mem_HSEL = 1'b1;
                bus.mem_we   = wr_q;
                bus.mem_re   = ~wr_q;
                // Base has the offset field cleared, so OR never carries.
                bus.mem_a    = base_q | (32'(beat_q) << 2);
                bus.rdata    = bus.mem_rd;
                bus.ack      = own_oh & {NUM_REQ{bus.mem_Valid}};
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (own_oh[i]) bus.mem_wd = bus.wdata[i];
                end
                if (beat_acc && last_beat) state_d = DONE;
            end
            DONE: begin
                bus.done = own_oh;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q   <= OWNER_NONE;
            rr_last_q <= REQ_IC;
            wr_q      <= 1'b0;
            base_q    <= '0;
            beat_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= winner;
                        wr_q    <= bus.wr[winner];
                        base_q  <= bus.addr[winner] & BASE_MASK;
                        beat_q  <= '0;
                        if (winner != REQ_MMU) rr_last_q <= winner;
                    end
                end
                BURST: begin
                    if (beat_acc) beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                end
                DONE: owner_q <= OWNER_NONE;
                default: owner_q <= OWNER_NONE;
            endcase
        end
    end

    assign bus.beat = beat_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter: a word memory slave plus a
// transaction-level reference (winner prediction, expected memory image).
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int BURST_LEN = 4;
    localparam int BEAT_W    = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.BURST_LEN(BURST_LEN), .BEAT_W(BEAT_W)) bus();

    mem_bus_arbiter #(.BURST_LEN(BURST_LEN), .BEAT_W(BEAT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    assign bus.mem_rd = mem[bus.mem_a[11:2]];
    always @(posedge clk)
        if (bus.mem_HSEL && bus.mem_we && bus.mem_Valid) mem[bus.mem_a[11:2]] <= bus.mem_wd;

    int checks = 0;
    int failures = 0;
    int rr_m = 2;

    logic [31:0] req_addr [3];
    logic [31:0] wbeat    [3][BURST_LEN];

    logic [31:0]       o_addr  [BURST_LEN];
    logic [31:0]       o_rdata [BURST_LEN];
    logic [31:0]       o_wd    [BURST_LEN];
    logic [BEAT_W-1:0] o_beat  [BURST_LEN];
    logic [2:0]        o_ack   [BURST_LEN];
    logic [2:0]        o_en    [BURST_LEN];
    logic [2:0]        o_gnt, o_done, o_done_gnt, o_done_en, o_stall_ack;
    logic [31:0]       o_stall_addr;
    int                o_ncyc, o_nstall;
    bit                o_timeout;

    function automatic int predict(input logic [2:0] rq);
        if (rq[0]) return 0;
        if (rq[1] && rq[2]) return (rr_m == 1) ? 2 : 1;
        if (rq[1]) return 1;
        if (rq[2]) return 2;
        return -1;
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a & ~32'(BURST_LEN * 4 - 1);
    endfunction

    // Drives one burst from an IDLE cycle through DONE and records what it saw.
    task automatic run_burst(input logic [2:0] rq, input logic [2:0] w, input logic [31:0] stall_mask,
                             input int stall_pct, input int drop_beat, input logic [2:0] hold);
        int b;
        int c;
        bit stall;
        bus.req = rq;
        bus.wr  = w;
        for (int k = 0; k < 3; k++) begin
            bus.addr[k]  = req_addr[k];
            bus.wdata[k] = wbeat[k][0];
        end
        bus.mem_Valid = 1'b1;
        o_stall_ack = '0; o_stall_addr = '0; o_nstall = 0;
        @(posedge clk); #1;
        o_gnt = bus.gnt;
        b = 0; c = 0;
        while (b < BURST_LEN && c < 200) begin
            for (int k = 0; k < 3; k++) bus.wdata[k] = wbeat[k][b];
            if (b == drop_beat) begin
                bus.req = 3'b000;
                for (int k = 0; k < 3; k++) bus.addr[k] = 32'h900;
            end
            stall = (c < 32 && stall_mask[c]) || (int'($urandom_range(99)) < stall_pct);
            bus.mem_Valid = !stall;
            #1;
            if (stall) begin
                o_stall_ack |= bus.ack;
                o_stall_addr = bus.mem_a;
                o_nstall++;
            end else begin
                o_addr[b]  = bus.mem_a;
                o_rdata[b] = bus.rdata;
                o_wd[b]    = bus.mem_wd;
                o_beat[b]  = bus.beat;
                o_ack[b]   = bus.ack;
                o_en[b]    = {bus.mem_HSEL, bus.mem_we, bus.mem_re};
                b++;
            end
            c++;
            @(posedge clk); #1;
        end
        o_ncyc     = c;
        o_timeout  = (b < BURST_LEN);
        o_done     = bus.done;
        o_done_gnt = bus.gnt;
        o_done_en  = {bus.mem_HSEL, bus.mem_we, bus.mem_re};
        bus.req    = bus.req & hold;
        bus.mem_Valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req = '0; bus.wr = '0; bus.addr = '0; bus.wdata = '0;
        bus.mem_Valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b want=000", bus.gnt); end
        checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL reset_ack got=%b want=000", bus.ack); end
        checks++; if (bus.done !== 3'b000) begin failures++; $display("FAIL reset_done got=%b want=000", bus.done); end
        checks++; if ({bus.mem_HSEL, bus.mem_we, bus.mem_re} !== 3'b000) begin failures++; $display("FAIL reset_en got=%b want=000", {bus.mem_HSEL, bus.mem_we, bus.mem_re}); end
        checks++; if (bus.mem_a !== 32'h0) begin failures++; $display("FAIL reset_mem_a got=%h want=0", bus.mem_a); end
        checks++; if (bus.mem_wd !== 32'h0) begin failures++; $display("FAIL reset_mem_wd got=%h want=0", bus.mem_wd); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", bus.rdata); end
        checks++; if (bus.beat !== '0) begin failures++; $display("FAIL reset_beat got=%0d want=0", bus.beat); end
        reset = 1'b0;
        rr_m = 2;
        @(posedge clk); #1;
        checks++; if (bus.gnt !== 3'b000) begin failures++; $display("FAIL idle_gnt got=%b want=000", bus.gnt); end
    endtask

    task automatic test_dcache_read;
        for (int i = 0; i < 4; i++) begin
            mem[64 + i] = 32'hA0 + i;
            ref_mem[64 + i] = 32'hA0 + i;
        end
        req_addr[1] = 32'h0000_0104;
        run_burst(3'b010, 3'b000, 32'h0, 0, -1, 3'b000);
        rr_m = 1;
        checks++; if (o_timeout) begin failures++; $display("FAIL rd_timeout got=timeout want=complete"); end
        checks++; if (o_gnt !== 3'b010) begin failures++; $display("FAIL rd_gnt got=%b want=010", o_gnt); end
        checks++; if (o_ncyc !== BURST_LEN) begin failures++; $display("FAIL rd_latency got=%0d want=%0d", o_ncyc, BURST_LEN); end
        for (int i = 0; i < BURST_LEN; i++) begin
            checks++; if (o_addr[i] !== 32'h100 + 4 * i) begin failures++; $display("FAIL rd_addr%0d got=%h want=%h", i, o_addr[i], 32'h100 + 4 * i); end
            checks++; if (o_rdata[i] !== 32'hA0 + i) begin failures++; $display("FAIL rd_data%0d got=%h want=%h", i, o_rdata[i], 32'hA0 + i); end
            checks++; if (o_beat[i] !== BEAT_W'(i)) begin failures++; $display("FAIL rd_beat%0d got=%0d want=%0d", i, o_beat[i], i); end
            checks++; if (o_ack[i] !== 3'b010) begin failures++; $display("FAIL rd_ack%0d got=%b want=010", i, o_ack[i]); end
            checks++; if (o_en[i] !== 3'b101) begin failures++; $display("FAIL rd_en%0d got=%b want=101", i, o_en[i]); end
        end
        checks++; if (o_done !== 3'b010) begin failures++; $display("FAIL rd_done got=%b want=010", o_done); end
        checks++; if (o_done_gnt !== 3'b000 || o_done_en !== 3'b000) begin failures++; $display("FAIL rd_done_bus got=%b/%b want=000/000", o_done_gnt, o_done_en); end
    endtask

    task automatic test_icache_write;
        req_addr[2] = 32'h0000_0200;
        wbeat[2][0] = 32'd11; wbeat[2][1] = 32'd22; wbeat[2][2] = 32'd33; wbeat[2][3] = 32'd44;
        run_burst(3'b100, 3'b100, 32'h0, 0, -1, 3'b000);
        rr_m = 2;
        for (int i = 0; i < BURST_LEN; i++) begin
            ref_mem[128 + i] = wbeat[2][i];
            checks++; if (o_en[i] !== 3'b110) begin failures++; $display("FAIL wr_en%0d got=%b want=110", i, o_en[i]); end
            checks++; if (o_wd[i] !== wbeat[2][i]) begin failures++; $display("FAIL wr_wd%0d got=%h want=%h", i, o_wd[i], wbeat[2][i]); end
            checks++; if (o_ack[i] !== 3'b100) begin failures++; $display("FAIL wr_ack%0d got=%b want=100", i, o_ack[i]); end
        end
        checks++; if (o_done !== 3'b100 || o_done_en !== 3'b000) begin failures++; $display("FAIL wr_done got=%b en=%b want=100 en=000", o_done, o_done_en); end
        req_addr[1] = 32'h0000_0208;
        run_burst(3'b010, 3'b000, 32'h0, 0, -1, 3'b000);
        rr_m = 1;
        for (int i = 0; i < BURST_LEN; i++) begin
            checks++; if (o_rdata[i] !== ref_mem[128 + i]) begin failures++; $display("FAIL wr_readback%0d got=%h want=%h", i, o_rdata[i], ref_mem[128 + i]); end
        end
    endtask

    task automatic test_contention;
        int exp;
        logic [2:0] rq;
        req_addr[0] = 32'h300; req_addr[1] = 32'h340; req_addr[2] = 32'h380;
        for (int n = 0; n < 6; n++) begin
            rq  = (n < 2) ? 3'b111 : 3'b110;
            exp = predict(rq);
            run_burst(rq, 3'b000, 32'h0, 0, -1, (n == 5) ? 3'b000 : ((n == 0) ? 3'b111 : 3'b110));
            if (exp != 0) rr_m = exp;
            checks++; if (o_gnt !== owner_onehot(owner_t'(exp))) begin failures++; $display("FAIL arb%0d_gnt got=%b want=%b", n, o_gnt, owner_onehot(owner_t'(exp))); end
            checks++; if (o_done !== owner_onehot(owner_t'(exp))) begin failures++; $display("FAIL arb%0d_done got=%b want=%b", n, o_done, owner_onehot(owner_t'(exp))); end
            checks++; if (o_addr[0] !== base_of(req_addr[exp])) begin failures++; $display("FAIL arb%0d_addr got=%h want=%h", n, o_addr[0], base_of(req_addr[exp])); end
        end
    endtask

    task automatic test_wait_states;
        req_addr[1] = 32'h104;
        run_burst(3'b010, 3'b000, 32'h6, 0, -1, 3'b000);
        rr_m = 1;
        checks++; if (o_ncyc !== 6) begin failures++; $display("FAIL ws_cycles got=%0d want=6", o_ncyc); end
        checks++; if (o_nstall !== 2) begin failures++; $display("FAIL ws_stalls got=%0d want=2", o_nstall); end
        checks++; if (o_stall_addr !== 32'h104) begin failures++; $display("FAIL ws_hold_addr got=%h want=104", o_stall_addr); end
        checks++; if (o_stall_ack !== 3'b000) begin failures++; $display("FAIL ws_stall_ack got=%b want=000", o_stall_ack); end
        checks++; if (o_addr[3] !== 32'h10C || o_beat[3] !== BEAT_W'(3)) begin failures++; $display("FAIL ws_last got=%h/%0d want=10c/3", o_addr[3], o_beat[3]); end
        checks++; if (o_done !== 3'b010) begin failures++; $display("FAIL ws_done got=%b want=010", o_done); end
    endtask

    task automatic test_mid_burst;
        req_addr[1] = 32'h104;
        run_burst(3'b010, 3'b000, 32'h0, 0, 1, 3'b000);
        rr_m = 1;
        checks++; if (o_addr[2] !== 32'h108 || o_addr[3] !== 32'h10C) begin failures++; $display("FAIL mid_addr got=%h,%h want=108,10c", o_addr[2], o_addr[3]); end
        checks++; if (o_timeout) begin failures++; $display("FAIL mid_timeout got=timeout want=complete"); end
        checks++; if (o_done !== 3'b010) begin failures++; $display("FAIL mid_done got=%b want=010", o_done); end
        @(posedge clk); #1;
        checks++; if (bus.gnt !== 3'b000) begin failures++; $display("FAIL mid_no_rearb got=%b want=000", bus.gnt); end
    endtask

    task automatic test_reset_mid_burst;
        for (int i = 0; i < BURST_LEN; i++) wbeat[2][i] = $urandom;
        bus.req = 3'b100; bus.wr = 3'b100; bus.addr[2] = 32'h100; bus.wdata[2] = wbeat[2][0];
        bus.mem_Valid = 1'b1;
        @(posedge clk); #1;
        bus.wdata[2] = wbeat[2][0];
        @(posedge clk); #1;
        bus.wdata[2] = wbeat[2][1];
        @(posedge clk); #1;
        bus.wdata[2] = wbeat[2][2];
        checks++; if (bus.beat !== BEAT_W'(2) || bus.mem_we !== 1'b1) begin failures++; $display("FAIL rst_pre got beat=%0d we=%b want beat=2 we=1", bus.beat, bus.mem_we); end
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_HSEL !== 1'b0) begin failures++; $display("FAIL rst_we got we=%b hsel=%b want 0/0", bus.mem_we, bus.mem_HSEL); end
        checks++; if ({bus.gnt, bus.ack, bus.done} !== 9'b0 || bus.mem_a !== 32'h0) begin failures++; $display("FAIL rst_out got=%b a=%h want=0", {bus.gnt, bus.ack, bus.done}, bus.mem_a); end
        bus.req = '0; bus.wr = '0;
        @(posedge clk); #1;
        checks++; if (bus.done !== 3'b000) begin failures++; $display("FAIL rst_no_done got=%b want=000", bus.done); end
        reset = 1'b0;
        rr_m = 2;
        ref_mem[64] = wbeat[2][0];
        ref_mem[65] = wbeat[2][1];
        checks++; if (mem[66] !== ref_mem[66] || mem[67] !== ref_mem[67]) begin failures++; $display("FAIL rst_unwritten got=%h,%h want=%h,%h", mem[66], mem[67], ref_mem[66], ref_mem[67]); end
        req_addr[1] = 32'h100;
        run_burst(3'b010, 3'b000, 32'h0, 0, -1, 3'b000);
        rr_m = 1;
        checks++; if (o_beat[0] !== '0 || o_addr[0] !== 32'h100) begin failures++; $display("FAIL rst_restart got=%0d/%h want=0/100", o_beat[0], o_addr[0]); end
        for (int i = 0; i < BURST_LEN; i++) begin
            checks++; if (o_rdata[i] !== ref_mem[64 + i]) begin failures++; $display("FAIL rst_read%0d got=%h want=%h", i, o_rdata[i], ref_mem[64 + i]); end
        end
    endtask

    task automatic test_random;
        logic [2:0] rq, w;
        logic [31:0] base;
        int o, idx;
        for (int n = 0; n < 40; n++) begin
            rq = 3'($urandom_range(1, 7));
            w  = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                req_addr[k] = $urandom;
                for (int i = 0; i < BURST_LEN; i++) wbeat[k][i] = $urandom;
            end
            o = predict(rq);
            base = base_of(req_addr[o]);
            run_burst(rq, w, 32'h0, 25, -1, 3'b000);
            if (o != 0) rr_m = o;
            checks++; if (o_timeout) begin failures++; $display("FAIL rnd%0d_timeout got=timeout want=complete", n); end
            checks++; if (o_gnt !== owner_onehot(owner_t'(o))) begin failures++; $display("FAIL rnd%0d_gnt got=%b want=%b", n, o_gnt, owner_onehot(owner_t'(o))); end
            checks++; if (o_done !== owner_onehot(owner_t'(o))) begin failures++; $display("FAIL rnd%0d_done got=%b want=%b", n, o_done, owner_onehot(owner_t'(o))); end
            checks++; if (o_stall_ack !== 3'b000) begin failures++; $display("FAIL rnd%0d_stall_ack got=%b want=000", n, o_stall_ack); end
            for (int i = 0; i < BURST_LEN; i++) begin
                idx = int'(((base >> 2) + 32'(i)) & 32'h3FF);
                checks++; if (o_addr[i] !== base + 32'(4 * i)) begin failures++; $display("FAIL rnd%0d_addr%0d got=%h want=%h", n, i, o_addr[i], base + 32'(4 * i)); end
                checks++; if (o_beat[i] !== BEAT_W'(i) || o_ack[i] !== owner_onehot(owner_t'(o))) begin failures++; $display("FAIL rnd%0d_beat%0d got=%0d/%b want=%0d/%b", n, i, o_beat[i], o_ack[i], i, owner_onehot(owner_t'(o))); end
                if (w[o]) begin
                    checks++; if (o_wd[i] !== wbeat[o][i]) begin failures++; $display("FAIL rnd%0d_wd%0d got=%h want=%h", n, i, o_wd[i], wbeat[o][i]); end
                    ref_mem[idx] = wbeat[o][i];
                end else begin
                    checks++; if (o_rdata[i] !== ref_mem[idx]) begin failures++; $display("FAIL rnd%0d_rd%0d got=%h want=%h", n, i, o_rdata[i], ref_mem[idx]); end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=no_finish want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        for (int k = 0; k < 3; k++) begin
            req_addr[k] = '0;
            for (int i = 0; i < BURST_LEN; i++) wbeat[k][i] = '0;
        end
        test_reset;
        test_dcache_read;
        test_icache_write;
        test_contention;
        test_wait_states;
        test_mid_burst;
        test_reset_mid_burst;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
